// File: rtl/overlap_add.sv
// rtl/overlap_add.sv - overlap-add of HOP_LEN-spaced frames into a continuous sample stream
// Define OVERLAP_ADD_SAT_EN for saturating output conversion with a sticky sat_flag.
module overlap_add #(
    parameter int I_BW              = 14,
    parameter int O_BW              = 14,
    parameter int ACC_BW            = 17,
    parameter int FRAME_LEN         = 1024,
    parameter int HOP_LEN           = 160,
    parameter int OUTPUT_TOTAL_DATA = 15104
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 di_en,
    input  logic [I_BW-1:0]                      data_i,
    input  logic                                 flush_i,
    output logic                                 in_ready,
    output logic                                 do_en,
    output logic [O_BW-1:0]                      data_o,
    output logic [$clog2(OUTPUT_TOTAL_DATA)-1:0] out_num,
    output logic                                 done
`ifdef OVERLAP_ADD_SAT_EN
    ,
    output logic                                 sat_flag
`endif
);
    localparam int NW = $clog2(OUTPUT_TOTAL_DATA);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW:0]   FRAME_W = (AW+1)'(FRAME_LEN);
    localparam logic [AW-1:0] HOP_W   = AW'(HOP_LEN);
    localparam logic [AW-1:0] LAST_K  = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] LAST_J  = AW'(FRAME_LEN - HOP_LEN - 1);
`ifdef OVERLAP_ADD_SAT_EN
    localparam logic signed [ACC_BW-1:0] O_MAX = ACC_BW'((1 << (O_BW - 1)) - 1);
    localparam logic signed [ACC_BW-1:0] O_MIN = ~O_MAX;
`endif

    typedef enum logic {ACCUM, FLUSH} state_t;
    state_t state, next_state;

    logic signed [ACC_BW-1:0] acc [FRAME_LEN];
    logic [AW-1:0] base, pos, addr, base_next;
    logic [AW:0]   addr_sum, base_sum;
    logic [NW-1:0] cnt;
    logic          accept, flush_go, flush_last, emit, last_q;
    logic signed [ACC_BW-1:0] sum;
    logic [O_BW-1:0] conv;
`ifdef OVERLAP_ADD_SAT_EN
    logic signed [ACC_BW-1:0] val;
    logic clip;
`endif

    // pos is k while accumulating and j while flushing; both restart at 0
    always_comb begin
        addr_sum  = {1'b0, base} + {1'b0, pos};
        addr      = (addr_sum >= FRAME_W) ? AW'(addr_sum - FRAME_W) : addr_sum[AW-1:0];
        base_sum  = {1'b0, base} + {1'b0, HOP_W};
        base_next = (base_sum >= FRAME_W) ? AW'(base_sum - FRAME_W) : base_sum[AW-1:0];
        sum        = acc[addr] + {{(ACC_BW-I_BW){data_i[I_BW-1]}}, data_i};
        accept     = di_en & in_ready;
        flush_go   = (state == ACCUM) & in_ready & flush_i & ~di_en & (pos == '0);
        flush_last = (state == FLUSH) & (pos == LAST_J);
        emit       = (accept & (pos < HOP_W)) | (state == FLUSH);
`ifdef OVERLAP_ADD_SAT_EN
        val  = (state == FLUSH) ? acc[addr] : sum;
        clip = 1'b1;
        if (val > O_MAX) begin
            conv = O_MAX[O_BW-1:0];
        end else if (val < O_MIN) begin
            conv = O_MIN[O_BW-1:0];
        end else begin
            conv = val[O_BW-1:0];
            clip = 1'b0;
        end
`else
        conv = (state == FLUSH) ? acc[addr][O_BW-1:0] : sum[O_BW-1:0];
`endif
    end

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (flush_go) next_state = FLUSH;
            FLUSH:   if (flush_last) next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ACCUM;
        else      state <= next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FRAME_LEN; i++) acc[i] <= '0;
            base     <= '0;
            pos      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            do_en    <= 1'b0;
            data_o   <= '0;
            last_q   <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= (next_state == ACCUM);
            do_en    <= emit;
            last_q   <= flush_last;
            done     <= last_q;
            // a slot is cleared as it is emitted so the next frame lap starts from zero
            if (emit) begin
                data_o    <= conv;
                cnt       <= cnt + NW'(1);
                acc[addr] <= '0;
            end else if (accept) begin
                acc[addr] <= sum;
            end
            if (accept) begin
                if (pos == LAST_K) begin
                    pos  <= '0;
                    base <= base_next;
                end else begin
                    pos <= pos + AW'(1);
                end
            end else if (state == FLUSH) begin
                if (flush_last) begin
                    pos  <= '0;
                    base <= '0;
                end else begin
                    pos <= pos + AW'(1);
                end
            end
        end
    end

`ifdef OVERLAP_ADD_SAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             sat_flag <= 1'b0;
        else if (emit & clip) sat_flag <= 1'b1;
    end
`endif

    assign out_num = cnt - NW'(1);

endmodule

// File: tb/tb_overlap_add.sv
// tb/tb_overlap_add.sv - overlap_add bench: small (8/2) and default (1024/160) lanes against a positional model
`timescale 1ns/1ps
module tb_overlap_add;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        di_en    [2];
    logic [13:0] data_i   [2];
    logic        flush_i  [2];
    logic        in_ready [2];
    logic        do_en    [2];
    logic        done     [2];
    logic [13:0] data_o   [2];
    logic [13:0] out_num  [2];
`ifdef OVERLAP_ADD_SAT_EN
    logic        sat_flag [2];
`endif

    int tests = 0;
    int fails = 0;
    int mcnt [2];
    int mlog0 [$];
    int mlog1 [$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int F = (g == 0) ? 8 : 1024;
        localparam int H = (g == 0) ? 2 : 160;

        overlap_add #(.FRAME_LEN(F), .HOP_LEN(H)) dut (
            .clk(clk), .rst(rst), .di_en(di_en[g]), .data_i(data_i[g]), .flush_i(flush_i[g]),
            .in_ready(in_ready[g]), .do_en(do_en[g]), .data_o(data_o[g]), .out_num(out_num[g]),
            .done(done[g])
`ifdef OVERLAP_ADD_SAT_EN
            , .sat_flag(sat_flag[g])
`endif
        );

        // Model: stream position p collects frame f sample k at p = f*H + k since the last clear.
        int y [int];
        int frame, k, j, flushing, ready_m, done_arm;
        int exp_do, exp_data, exp_done, exp_sat;

        task automatic put_out(input int v);
            int r;
`ifdef OVERLAP_ADD_SAT_EN
            r = v;
            if (v > 8191) begin r = 8191; exp_sat = 1; end
            else if (v < -8192) begin r = -8192; exp_sat = 1; end
`else
            r = v & 32'h3FFF;
            if (r >= 8192) r -= 16384;
`endif
            exp_do   = 1;
            exp_data = r;
            mcnt[g]++;
            if (g == 0) mlog0.push_back(r);
            else        mlog1.push_back(r);
        endtask

        always @(posedge clk or negedge rst) begin : mdl
            int p;
            if (!rst) begin
                y.delete();
                frame = 0; k = 0; j = 0; flushing = 0; ready_m = 0; done_arm = 0;
                exp_do = 0; exp_data = 0; exp_done = 0; exp_sat = 0; mcnt[g] = 0;
            end else begin
                exp_done = done_arm;
                done_arm = 0;
                exp_do   = 0;
                if (flushing != 0) begin
                    p = frame * H + j;
                    put_out(y.exists(p) ? y[p] : 0);
                    j++;
                    if (j == F - H) begin
                        flushing = 0; done_arm = 1; y.delete(); frame = 0; k = 0;
                    end
                end else if (ready_m != 0 && di_en[g]) begin
                    p = frame * H + k;
                    if (!y.exists(p)) y[p] = 0;
                    y[p] += int'($signed(data_i[g]));
                    if (k < H) put_out(y[p]);
                    k++;
                    if (k == F) begin k = 0; frame++; end
                end else if (ready_m != 0 && flush_i[g] && k == 0) begin
                    flushing = 1; j = 0;
                end
                ready_m = (flushing == 0) ? 1 : 0;
            end
        end

        always @(negedge clk) begin
            chk($sformatf("lane%0d do_en", g), int'(do_en[g]), exp_do);
            chk($sformatf("lane%0d in_ready", g), int'(in_ready[g]), ready_m);
            chk($sformatf("lane%0d done", g), int'(done[g]), exp_done);
            if (exp_do != 0 || !rst)
                chk($sformatf("lane%0d data_o", g), int'($signed(data_o[g])), exp_data);
            if (exp_do != 0)
                chk($sformatf("lane%0d out_num", g), int'(out_num[g]), (mcnt[g] - 1) & 32'h3FFF);
`ifdef OVERLAP_ADD_SAT_EN
            chk($sformatf("lane%0d sat_flag", g), int'(sat_flag[g]), exp_sat);
`endif
        end
    end

    task automatic push(input int g, input int v);
        int n = 0;
        di_en[g] = 1'b0;
        while (!in_ready[g] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("in_ready_timeout", 0, 1);
        di_en[g]  = 1'b1;
        data_i[g] = 14'(v);
        @(negedge clk);
    endtask

    task automatic idle(input int g, input int n);
        di_en[g] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frames(input int g, input int len, input int v, input int toggle);
        for (int i = 0; i < len; i++) begin
            push(g, v);
            if (toggle != 0) idle(g, 1);
        end
        idle(g, 1);
    endtask

    task automatic do_flush(input int g, input int lim);
        int n = 0;
        di_en[g]   = 1'b0;
        flush_i[g] = 1'b1;
        @(negedge clk);
        flush_i[g] = 1'b0;
        while (!done[g] && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("flush_done_seen", int'(done[g]), 1);
        @(negedge clk);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            di_en[g] = 1'b0; data_i[g] = '0; flush_i[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset do_en", int'(do_en[0]), 0);
        chk("reset data_o", int'(data_o[0]), 0);
        chk("reset in_ready", int'(in_ready[0]), 0);
        chk("reset done", int'(done[1]), 0);
        chk("reset out_num", int'(out_num[0]), 16383);
        #2 rst = 1'b1;
        @(negedge clk);

        // four frames of ones, then flush, then a fresh frame
        send_frames(0, 32, 1, 0);
        for (int i = 0; i < 8; i++) chk("frames4 model", mlog0[i], (i / 2) + 1);
        do_flush(0, 20);
        for (int i = 0; i < 6; i++) chk("flush model", mlog0[8 + i], 3 - i / 2);
        send_frames(0, 8, 1, 0);
        chk("post flush a", mlog0[14], 1);
        chk("post flush b", mlog0[15], 1);

        // flush at k=3 is ignored, flush tied with di_en at k=0 is ignored
        for (int i = 0; i < 3; i++) push(0, 1);
        di_en[0] = 1'b0; flush_i[0] = 1'b1;
        @(negedge clk);
        flush_i[0] = 1'b0;
        chk("flush k3 ignored", int'(in_ready[0]), 1);
        for (int i = 0; i < 5; i++) push(0, 1);
        flush_i[0] = 1'b1;
        push(0, 1);
        flush_i[0] = 1'b0;
        for (int i = 0; i < 7; i++) push(0, 1);
        idle(0, 2);
        chk("no flush a", mlog0[16], 2);
        chk("no flush b", mlog0[17], 2);
        chk("no flush c", mlog0[18], 3);

        // asynchronous reset while do_en is high
        push(0, 7);
        di_en[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async rst do_en", int'(do_en[0]), 0);
        chk("async rst data_o", int'(data_o[0]), 0);
        chk("async rst in_ready", int'(in_ready[0]), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        send_frames(0, 8, 5, 0);
        chk("after rst a", mlog0[mlog0.size() - 2], 5);
        chk("after rst b", mlog0[mlog0.size() - 1], 5);
        chk("after rst count", mcnt[0], 2);

        // default lane, full-scale input with di_en toggling
        send_frames(1, 8 * 1024, 8191, 1);
        chk("big frame0", mlog1[0], 8191);
`ifdef OVERLAP_ADD_SAT_EN
        chk("big 2x", mlog1[160], 8191);
        chk("big 7x", mlog1[1120], 8191);
        chk("big 6x", mlog1[1220], 8191);
        chk("big sat_flag", int'(sat_flag[1]), 1);
`else
        chk("big 2x", mlog1[160], -2);
        chk("big 7x", mlog1[1120], 8185);
        chk("big 6x", mlog1[1220], -6);
`endif
        do_flush(1, 1100);

        // randomized data, gaps and flush requests
        for (int i = 0; i < 160; i++) begin
            push(0, int'($urandom_range(0, 16383)) - 8192);
            if ($urandom_range(0, 3) == 0) begin
                di_en[0]   = 1'b0;
                flush_i[0] = ($urandom_range(0, 2) == 0);
                @(negedge clk);
                flush_i[0] = 1'b0;
            end
        end
        do_flush(0, 20);
        for (int i = 0; i < 3 * 1024; i++) begin
            push(1, int'($urandom_range(0, 16383)) - 8192);
            if ($urandom_range(0, 3) == 0) begin
                di_en[1]   = 1'b0;
                flush_i[1] = ($urandom_range(0, 63) == 0);
                @(negedge clk);
                flush_i[1] = 1'b0;
            end
        end
        do_flush(1, 1100);
        idle(0, 10);
        idle(1, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
